conv1d_mac_engine: RTL and testbench
====================================

Name: conv1d_mac_engine

Overview:
- Parametrised, sequential successor to the fixed 4x4 combinational 1D convolution unit used by the RISC-V CNN accelerator.
- Computes the full linear convolution y = x * h of an N-sample input vector and a K-tap kernel using a single time-multiplexed multiply-accumulate unit.
- Accepts one operand pair per transaction over a valid/ready handshake and streams the N+K-1 results out over a second valid/ready handshake, with an end-of-vector marker.
- Sits between the custom-instruction operand decode and the writeback/packing logic.

Parameters:
- DW, 5: bit width of each x and h element.
- N, 4: number of input samples.
- K, 4: number of kernel taps.
- SIGNED, 0: 0 means elements are unsigned; 1 means elements are two's complement.
- ACC_W, 2*DW+$clog2(min(N,K))+SIGNED: accumulator and output width. Must not be overridden smaller than the default; elaboration error if it is.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept an operand pair.
- x_vec  in  N*DW  samples; x[i] = x_vec[i*DW +: DW].
- h_vec  in  K*DW  taps; h[j] = h_vec[j*DW +: DW].
- out_valid  out  1  out_data holds y[k].
- out_ready  in  1  consumer accepts y[k].
- out_data  out  ACC_W  y[k], sign-extended when SIGNED=1.
- out_idx  out  $clog2(N+K-1)  current k.
- out_last  out  1  high with out_valid when k = N+K-2.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - state=IDLE; k=0; acc=0; term index=0.
  - out_valid=0, out_last=0, out_data=0, out_idx=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Reset is honoured in every state and aborts any operation in flight; a partial result is never emitted.
- State machine:
  - IDLE:
    - in_ready=1.
    - On in_valid && in_ready: register x_vec and h_vec; k=0; acc=0; i=max(0,k-K+1); go to MAC.
  - MAC:
    - One product per cycle: acc += x[i]*h[k-i]; i++.
    - When i = min(k,N-1) this cycle, go to EMIT.
    - The number of cycles for y[k] is terms(k) = min(k,N-1) - max(0,k-K+1) + 1.
  - EMIT:
    - out_valid=1; out_data=acc; out_idx=k; out_last=(k==N+K-2).
    - On out_ready=1:
      - If out_last, go to IDLE.
      - Otherwise k++, acc=0, i=max(0,k_new-K+1), and go to MAC.
    - While out_ready=0, all outputs are held stable.
- Handshakes:
  - in_ready=0 in MAC and EMIT; in_valid is ignored there.
  - Operands are captured only at acceptance; later changes to x_vec/h_vec do not affect the result.
  - out_valid never deasserts without a handshake, except on reset.
- Latency with out_ready held at 1:
  - y[k] is valid terms(k) cycles after entering MAC for that k.
  - Total from the accept edge to the return to IDLE is N*K + N+K-1 cycles (23 cycles at the defaults).
  - The next operand pair can be accepted in the first IDLE cycle; there is no back-to-back overlap.
- Arithmetic:
  - Products are 2*DW bits, signed or unsigned per SIGNED.
  - The accumulator is ACC_W bits and cannot overflow at the default width.
  - There is no saturation and no rounding.
- Degenerate sizes:
  - N=1 or K=1 is legal; each y[k] then has exactly one term.
  - N, K >= 1 is checked at elaboration.

Decomposition:
- Package conv_pkg holds:
  - the state enum {IDLE, MAC, EMIT};
  - a function acc_width(DW,N,K,SIGNED);
  - functions lo_idx(k) = max(0,k-K+1) and hi_idx(k) = min(k,N-1).
- Sub-module conv_mac (DW, ACC_W, SIGNED):
  - registered multiply-accumulate with clear and enable;
  - clear takes priority over enable.
- The FSM, operand registers and index counters live in the top module.

Test Plan:
- Defaults, x={1,2,3,4} (x0 first), h={1,1,1,1}, out_ready=1 -> y = 1,3,6,10,9,7,4; out_idx runs 0..6; out_last only with 4; busy for 23 cycles.
- Defaults, every x and h element = 31 -> y = 961,1922,2883,3844,2883,1922,961; no overflow.
- SIGNED=1 with DW=5, every x and h element = -16 -> y = 256,512,768,1024,768,512,256. Then x={-1,2,-3,4}, h={1,0,0,0} -> y = -1,2,-3,4,0,0,0.
- Backpressure: out_ready=0 for 3 cycles while y[2] is presented -> out_valid, out_data=6 and out_idx=2 held stable, in_ready=0; the stream resumes correctly.
- Mid-operation changes:
  - change x_vec after acceptance -> results unchanged;
  - assert in_valid during MAC -> ignored;
  - rst_n=0 for 1 cycle during MAC for y[4] -> next cycle out_valid=0, in_ready=1, busy=0; a new transaction then yields the correct sequence.
- N=3, K=2, DW=8, x={255,1,2}, h={2,3} -> y = 510,767,7,6; total 6+4 = 10 cycles.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type plus sizing and term-range helpers for the 1D convolution engine
package conv_pkg;
  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;
  function automatic int min2(input int a, input int b);
    return a < b ? a : b;
  endfunction
  function automatic int acc_width(input int dw, input int n, input int k, input int s);
    return 2 * dw + $clog2(min2(n, k)) + s;
  endfunction
  function automatic int idx_width(input int n, input int k);
    return n + k - 1 > 1 ? $clog2(n + k - 1) : 1;
  endfunction
  function automatic int lo_idx(input int k, input int taps);
    return k - taps + 1 > 0 ? k - taps + 1 : 0;
  endfunction
  function automatic int hi_idx(input int k, input int n);
    return min2(k, n - 1);
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered multiply-accumulate, clear has priority over enable
// ports: clk, rst_n (sync active-low), clr, en, a/b operands (DW), acc running sum (ACC_W)
module conv_mac #(
  parameter int DW = 5,
  parameter int ACC_W = 12,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);
  logic [ACC_W-1:0] ae, be, prod;
  // extending both operands to ACC_W first gives the exact product modulo 2^ACC_W for either signedness
  always_comb begin
    ae = SIGNED != 0 ? {{(ACC_W-DW){a[DW-1]}}, a} : {{(ACC_W-DW){1'b0}}, a};
    be = SIGNED != 0 ? {{(ACC_W-DW){b[DW-1]}}, b} : {{(ACC_W-DW){1'b0}}, b};
    prod = ae * be;
  end
  always_ff @(posedge clk)
    if (!rst_n || clr) acc <= '0;
    else if (en) acc <= acc + prod;
endmodule

// File: rtl/conv1d_mac_engine.sv
// conv1d_mac_engine: sequential full linear convolution y = x * h through one time-multiplexed MAC
// ports: clk, rst_n (sync active-low); in_valid/in_ready accept x_vec (N*DW) and h_vec (K*DW);
//        out_valid/out_ready stream out_data (ACC_W) with out_idx k and out_last; busy outside IDLE
module conv1d_mac_engine import conv_pkg::*; #(
  parameter int DW = 5,
  parameter int N = 4,
  parameter int K = 4,
  parameter int SIGNED = 0,
  parameter int ACC_W = acc_width(DW, N, K, SIGNED),
  localparam int IW = idx_width(N, K)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*DW-1:0]  x_vec,
  input  logic [K*DW-1:0]  h_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy
);
  state_t state, nxt;
  logic [N*DW-1:0] x_r;
  logic [K*DW-1:0] h_r;
  logic [IW-1:0] k, i;
  logic [ACC_W-1:0] acc;
  logic [DW-1:0] xa, hb;
  logic accept, last, mac_done, clr;
  if (N < 1 || K < 1) begin : g_chk_size
    $error("conv1d_mac_engine: N and K must be at least 1");
  end
  if (ACC_W < acc_width(DW, N, K, SIGNED)) begin : g_chk_acc
    $error("conv1d_mac_engine: ACC_W is narrower than the overflow-free width");
  end
  always_comb begin
    accept = state == IDLE && in_valid;
    last = state == EMIT && int'(k) == N + K - 2;
    mac_done = int'(i) == hi_idx(int'(k), N);
    // advancing to the next output restarts the sum; acceptance starts y[0]
    clr = accept || (state == EMIT && out_ready && !last);
    xa = x_r[int'(i)*DW +: DW];
    hb = h_r[(int'(k) - int'(i))*DW +: DW];
    nxt = state == IDLE ? (in_valid ? MAC : IDLE) :
          state == MAC  ? (mac_done ? EMIT : MAC) :
          out_ready     ? (last ? IDLE : MAC) : EMIT;
    in_ready = state == IDLE;
    out_valid = state == EMIT;
    busy = state != IDLE;
    out_data = out_valid ? acc : '0;
    out_idx = out_valid ? k : '0;
    out_last = last;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      i <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        x_r <= x_vec;
        h_r <= h_vec;
        k <= '0;
        i <= '0;
      end else if (state == MAC) i <= i + 1'b1;
      else if (clr) begin
        k <= k + 1'b1;
        i <= IW'(lo_idx(int'(k) + 1, K));
      end
    end
  conv_mac #(.DW(DW), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(state == MAC), .a(xa), .b(hb), .acc(acc)
  );
endmodule

// File: tb/tb_conv1d_mac_engine.sv
// tb_conv1d_mac_engine: directed vector table plus hand sequences for backpressure, mid-op changes and reset
module tb_conv1d_mac_engine;
  typedef struct { int d; int idx; bit last; } obs_t;
  typedef struct { int sel; logic [19:0] x; logic [19:0] h; logic [6:0][15:0] y; } vec_t;
  logic clk = 0, rst_n = 0, out_ready = 1;
  logic iv0 = 0, iv1 = 0, iv2 = 0;
  logic ir0, ir1, ir2, ov0, ov1, ov2, ol0, ol1, ol2, bz0, bz1, bz2;
  logic [19:0] xv0 = '0, hv0 = '0, xv1 = '0, hv1 = '0;
  logic [23:0] xv2 = '0;
  logic [15:0] hv2 = '0;
  logic [11:0] od0;
  logic [12:0] od1;
  logic [16:0] od2;
  logic [2:0] oi0, oi1;
  logic [1:0] oi2;
  obs_t q0[$], q1[$], q2[$];
  int bt0 = 0, bt1 = 0, bt2 = 0, b0s, b1s, b2s;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  conv1d_mac_engine dut0 (.clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .x_vec(xv0), .h_vec(hv0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_idx(oi0), .out_last(ol0), .busy(bz0));
  conv1d_mac_engine #(.SIGNED(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .x_vec(xv1),
    .h_vec(hv1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_idx(oi1), .out_last(ol1), .busy(bz1));
  conv1d_mac_engine #(.DW(8), .N(3), .K(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .x_vec(xv2), .h_vec(hv2), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_idx(oi2),
    .out_last(ol2), .busy(bz2));
  always @(negedge clk) begin
    if (ov0 && out_ready) q0.push_back('{int'(od0), int'(oi0), ol0});
    if (ov1 && out_ready) q1.push_back('{int'($signed(od1)), int'(oi1), ol1});
    if (ov2 && out_ready) q2.push_back('{int'(od2), int'(oi2), ol2});
    bt0 = bt0 + (bz0 ? 1 : 0);
    bt1 = bt1 + (bz1 ? 1 : 0);
    bt2 = bt2 + (bz2 ? 1 : 0);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end
  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction
  function automatic logic [6:0][15:0] py(input int a0, a1, a2, a3, a4, a5, a6);
    return {16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction
  function automatic int qsize(input int sel);
    return sel == 0 ? q0.size() : sel == 1 ? q1.size() : q2.size();
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask
  task automatic start(input int sel, input logic [19:0] x, input logic [19:0] h);
    @(posedge clk); #1;
    if (sel == 0) begin xv0 = x; hv0 = h; iv0 = 1; b0s = bt0; end
    else begin xv1 = x; hv1 = h; iv1 = 1; b1s = bt1; end
    @(posedge clk); #1;
    iv0 = 0;
    iv1 = 0;
  endtask
  task automatic wait_q(input int sel, input int target);
    int c = 0;
    while (qsize(sel) < target && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (c >= 300) chk("timeout_outputs", qsize(sel), target);
    repeat (3) @(negedge clk);
  endtask
  task automatic check7(input int sel, input int base, input logic [6:0][15:0] y, input string tag);
    obs_t o;
    chk({tag, "_count"}, qsize(sel) - base, 7);
    for (int e = 0; e < 7; e++) begin
      o = base + e >= qsize(sel) ? '{-99999, -1, 1'b0} : sel == 0 ? q0[base+e] : q1[base+e];
      chk($sformatf("%s_y%0d", tag, e), o.d, int'($signed(y[e])));
      chk($sformatf("%s_idx%0d", tag, e), o.idx, e);
      chk($sformatf("%s_last%0d", tag, e), int'(o.last), e == 6 ? 1 : 0);
    end
  endtask
  initial begin
    vec_t tv[4];
    int base, ok, found;
    int e2[4] = '{510, 767, 7, 6};
    obs_t o;
    tv[0] = '{0, pk(1, 2, 3, 4), pk(1, 1, 1, 1), py(1, 3, 6, 10, 9, 7, 4)};
    tv[1] = '{0, pk(31, 31, 31, 31), pk(31, 31, 31, 31), py(961, 1922, 2883, 3844, 2883, 1922, 961)};
    tv[2] = '{1, pk(-16, -16, -16, -16), pk(-16, -16, -16, -16), py(256, 512, 768, 1024, 768, 512, 256)};
    tv[3] = '{1, pk(-1, 2, -3, 4), pk(1, 0, 0, 0), py(-1, 2, -3, 4, 0, 0, 0)};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", ir0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_out_data", od0, 0);
    chk("rst_out_idx", oi0, 0);
    chk("rst_out_last", ol0, 0);
    chk("rst_in_ready_s", ir1, 1);
    chk("rst_in_ready_n3k2", ir2, 1);
    for (int t = 0; t < 4; t++) begin
      base = qsize(tv[t].sel);
      start(tv[t].sel, tv[t].x, tv[t].h);
      wait_q(tv[t].sel, base + 7);
      check7(tv[t].sel, base, tv[t].y, $sformatf("vec%0d", t));
      chk($sformatf("vec%0d_busy_cycles", t), tv[t].sel == 0 ? bt0 - b0s : bt1 - b1s, 23);
    end
    out_ready = 0;
    base = q0.size();
    start(0, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    xv0 = pk(7, 7, 7, 7);
    hv0 = pk(9, 9, 9, 9);
    iv0 = 1;
    @(negedge clk);
    chk("bp_in_ready_mac", ir0, 0);
    for (int e = 0; e < 7; e++) begin
      ok = 0;
      for (int c = 0; c < 100 && ok == 0; c++) begin
        @(negedge clk);
        ok = ov0 ? 1 : 0;
      end
      chk($sformatf("bp_valid%0d", e), ok, 1);
      if (e == 2)
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_valid", ov0, 1);
          chk("bp_hold_data", od0, 6);
          chk("bp_hold_idx", oi0, 2);
          chk("bp_hold_in_ready", ir0, 0);
        end
      if (e == 6) iv0 = 0;
      @(posedge clk); #1 out_ready = 1;
      @(posedge clk); #1 out_ready = 0;
    end
    out_ready = 1;
    repeat (3) @(negedge clk);
    check7(0, base, py(1, 3, 6, 10, 9, 7, 4), "bp");
    chk("bp_idle_after", bz0, 0);
    base = q0.size();
    start(0, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      found = (ov0 && oi0 == 3) ? 1 : 0;
    end
    chk("rstmid_reach_y3", found, 1);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rstmid_out_valid", ov0, 0);
    chk("rstmid_in_ready", ir0, 1);
    chk("rstmid_busy", bz0, 0);
    chk("rstmid_out_data", od0, 0);
    repeat (5) @(negedge clk);
    chk("rstmid_no_partial", q0.size() - base, 4);
    base = q0.size();
    start(0, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    wait_q(0, base + 7);
    check7(0, base, py(1, 3, 6, 10, 9, 7, 4), "rstmid_rerun");
    base = q2.size();
    @(posedge clk); #1;
    xv2 = {8'd2, 8'd1, 8'd255};
    hv2 = {8'd3, 8'd2};
    iv2 = 1;
    b2s = bt2;
    @(posedge clk); #1 iv2 = 0;
    wait_q(2, base + 4);
    chk("n3k2_count", q2.size() - base, 4);
    for (int e = 0; e < 4; e++) begin
      o = base + e >= q2.size() ? '{-99999, -1, 1'b0} : q2[base+e];
      chk($sformatf("n3k2_y%0d", e), o.d, e2[e]);
      chk($sformatf("n3k2_idx%0d", e), o.idx, e);
      chk($sformatf("n3k2_last%0d", e), int'(o.last), e == 3 ? 1 : 0);
    end
    chk("n3k2_busy_cycles", bt2 - b2s, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
